wb_slave_regfile: RTL and testbench
===================================

# wb_slave_regfile

Wishbone B3 classic-cycle slave exposing a bank of `NUM_REGS` 32-bit read/write registers with byte-lane writes, programmable wait states, error response on bad addresses and retry response while the owner logic is busy. It is the responder counterpart of the team's Wishbone bus master and the standard target for DSP control/status registers. Register contents are presented in parallel to the datapath.

## Interface
- `dw`, 32, data width (fixed 32; `wb_sel_i` is 4 bits)
- `aw`, 32, address width
- `NUM_REGS`, 16, number of registers (1..256)
- `BASE_ADDR`, 32'h0, byte address of register 0 (word aligned)
- `WAIT_STATES`, 0, extra cycles before response (0..15)

- `wb_clk`  in  1  clock; all logic on rising edge
- `wb_rst`  in  1  reset; synchronous, active-high
- `wb_adr_i`  in  aw  byte address
- `wb_dat_i`  in  dw  write data
- `wb_sel_i`  in  4  byte lane enables; bit n covers `[8n+7:8n]`
- `wb_we_i`  in  1  1 = write
- `wb_cyc_i`  in  1  cycle valid
- `wb_stb_i`  in  1  strobe
- `wb_cti_i`  in  3  ignored (classic only)
- `wb_bte_i`  in  2  ignored
- `wb_dat_o`  out  dw  read data, registered
- `wb_ack_o`  out  1  normal termination, registered
- `wb_err_o`  out  1  error termination, registered
- `wb_rty_o`  out  1  retry termination, registered
- `busy_i`  in  1  owner busy; requests sampled while high get retry
- `reg_q`  out  NUM_REGS*dw  register contents, register k at `[k*dw +: dw]`
- `wr_stb_o`  out  1  one-cycle pulse when a write commits
- `wr_idx_o`  out  8  index of committed register, valid with `wr_stb_o`

## Operation
- Decode: `offset = wb_adr_i - BASE_ADDR` (aw-bit, modulo). Valid iff `offset[1:0]==0` and `offset < NUM_REGS*4`; index = `offset >> 2`. Addresses below `BASE_ADDR` wrap to large offsets and are invalid.
- FSM states: IDLE, WAIT, RESP.
- IDLE: request = `wb_cyc_i & wb_stb_i`. On request, priority: `busy_i` -> RESP with rty; else invalid -> RESP with err; else `WAIT_STATES==0` -> RESP with ack; else WAIT with counter = `WAIT_STATES-1`. Address, data, sel, we captured on this edge.
- WAIT: if `wb_cyc_i` or `wb_stb_i` low -> IDLE, abort (no write, no response). Else counter 0 -> RESP with ack, else decrement.
- RESP: exactly one of ack/err/rty high for one cycle, then IDLE unconditionally.
- Write commit: on the edge entering RESP-with-ack; only lanes with `wb_sel_i` bit set change; `wb_sel_i==0` acks with no change. `wr_stb_o`/`wr_idx_o` high in that RESP cycle.
- Read: `wb_dat_o` loaded with register value on entry to RESP-with-ack; 0 in every other cycle, including err/rty cycles.
- err/rty: no register change, no `wr_stb_o`.
- `busy_i` sampled only in IDLE; changes during WAIT have no effect.

## Timing
- Reset: state IDLE, all registers 0, `reg_q`=0, `wb_dat_o`=0, `wb_ack_o`/`wb_err_o`/`wb_rty_o`=0, `wr_stb_o`=0, `wr_idx_o`=0. Reset mid-transaction drops it with no response and clears any write already committed.
- Latency: request first present in cycle N -> response high in cycle N+1+WAIT_STATES. err/rty always cycle N+1.
- Back-to-back: response cycle returns to IDLE; a request held or reasserted in the cycle after response is treated as a new request. Minimum transfer period 2 cycles (WAIT_STATES=0).
- `reg_q` reflects a write starting in the ack cycle.
- Responses never asserted while `wb_cyc_i` was low on the sampling edge.

## Test plan
- BASE_ADDR=0x100, WAIT_STATES=0: write 0xDEADBEEF sel=0xF to 0x108 -> ack 1 cycle after request, `reg_q[95:64]`=0xDEADBEEF, `wr_stb_o`=1, `wr_idx_o`=2; read 0x108 -> `wb_dat_o`=0xDEADBEEF with ack.
- Byte lanes: reg 0 = 0x11223344, write 0xAABBCCDD sel=0x5 -> reg 0 = 0x11BB33DD; sel=0x0 -> ack, unchanged, `wr_stb_o` pulses.
- Errors: read 0x140 (index 16), 0x102 (misaligned), 0x0FC (below base) -> `wb_err_o` 1 cycle, `wb_dat_o`=0, registers unchanged.
- `busy_i`=1 at request -> `wb_rty_o` next cycle, no write; `busy_i` rising during WAIT -> still ack.
- WAIT_STATES=3: request at cycle 10 -> ack in cycle 14; dropping `wb_stb_i` in cycle 12 -> no response, no write; `wb_rst` in cycle 12 -> all outputs and registers 0.

Source files
------------

// File: rtl/wb_slave_regfile.sv
// rtl/wb_slave_regfile.sv - Wishbone B3 classic slave with a byte-writable register bank
//
// Ports:
//   wb_clk, wb_rst          clock, synchronous active-high reset
//   wb_adr_i .. wb_bte_i    Wishbone slave inputs (cti/bte ignored, classic cycles only)
//   wb_dat_o, wb_ack_o,
//   wb_err_o, wb_rty_o      registered read data and cycle terminations
//   busy_i                  owner busy; a request seen while high is answered with retry
//   reg_q                   all registers in parallel, register k at [k*dw +: dw]
//   wr_stb_o, wr_idx_o      one-cycle pulse and register index of a committed write
module wb_slave_regfile #(
    parameter int            dw          = 32,
    parameter int            aw          = 32,
    parameter int            NUM_REGS    = 16,
    parameter logic [aw-1:0] BASE_ADDR   = '0,
    parameter int            WAIT_STATES = 0
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [aw-1:0]          wb_adr_i,
    input  logic [dw-1:0]          wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic [2:0]             wb_cti_i,
    input  logic [1:0]             wb_bte_i,
    output logic [dw-1:0]          wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    input  logic                   busy_i,
    output logic [NUM_REGS*dw-1:0] reg_q,
    output logic                   wr_stb_o,
    output logic [7:0]             wr_idx_o
);

    localparam int            IW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [aw-1:0] LIMIT = aw'(NUM_REGS * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [7:0]      r_idx;
    logic [dw-1:0]   r_dat;
    logic [3:0]      r_sel;
    logic            r_we;
    logic [dw-1:0]   r_regs [NUM_REGS];

    logic [aw-1:0]   w_offset;
    logic            w_valid;
    logic [7:0]      w_idx;
    logic            w_req;
    logic            w_commit;
    logic [7:0]      w_cidx;
    logic [dw-1:0]   w_cdat;
    logic [3:0]      w_csel;
    logic            w_cwe;
    logic            w_unused;

    // Modulo subtraction makes addresses below the base wrap to huge offsets,
    // so a single range compare rejects them.
    assign w_offset = wb_adr_i - BASE_ADDR;
    assign w_valid  = (w_offset[1:0] == 2'b00) && (w_offset < LIMIT);
    assign w_idx    = w_offset[9:2];
    assign w_req    = wb_cyc_i & wb_stb_i;

    // An ack commits either straight from the bus (no wait states) or from
    // the fields captured in IDLE once the wait counter expires.
    always_comb begin
        w_commit = 1'b0;
        w_cidx   = r_idx;
        w_cdat   = r_dat;
        w_csel   = r_sel;
        w_cwe    = r_we;
        if (r_state == S_IDLE) begin
            w_commit = w_req && !busy_i && w_valid && (WAIT_STATES == 0);
            w_cidx   = w_idx;
            w_cdat   = wb_dat_i;
            w_csel   = wb_sel_i;
            w_cwe    = wb_we_i;
        end else if (r_state == S_WAIT) begin
            w_commit = w_req && (r_cnt == 4'd0);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= 8'd0;
            r_dat    <= '0;
            r_sel    <= 4'd0;
            r_we     <= 1'b0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_rty_o <= 1'b0;
            wr_stb_o <= 1'b0;
            wr_idx_o <= 8'd0;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else begin
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_rty_o <= 1'b0;
            wr_stb_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx <= w_idx;
                        r_dat <= wb_dat_i;
                        r_sel <= wb_sel_i;
                        r_we  <= wb_we_i;
                        if (busy_i) begin
                            wb_rty_o <= 1'b1;
                            r_state  <= S_RESP;
                        end else if (!w_valid) begin
                            wb_err_o <= 1'b1;
                            r_state  <= S_RESP;
                        end else if (WAIT_STATES == 0) begin
                            wb_ack_o <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_cnt   <= 4'(WAIT_STATES - 1);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Master withdrawing the cycle aborts silently.
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        wb_ack_o <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_commit) begin
                if (w_cwe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_csel[b]) r_regs[w_cidx[IW-1:0]][8*b +: 8] <= w_cdat[8*b +: 8];
                    end
                    wr_stb_o <= 1'b1;
                    wr_idx_o <= w_cidx;
                end else begin
                    wb_dat_o <= r_regs[w_cidx[IW-1:0]];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_q
        assign reg_q[k*dw +: dw] = r_regs[k];
    end

    assign w_unused = ^{wb_cti_i, wb_bte_i};

endmodule

// File: tb/tb_wb_slave_regfile.sv
// tb/tb_wb_slave_regfile.sv - randomized self-checking bench for wb_slave_regfile
module tb_wb_slave_regfile;

    localparam logic [31:0] BASE = 32'h100;
    localparam int          NR   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   adr, dat_i;
    logic [3:0]    sel;
    logic          we, stb, busy, cyc0, cyc1;
    logic [2:0]    cti;
    logic [1:0]    bte;

    logic [31:0]   dat_o0, dat_o1;
    logic          ack0, err0, rty0, ack1, err1, rty1, wstb0, wstb1;
    logic [511:0]  regq0, regq1;
    logic [7:0]    widx0, widx1;

    logic [31:0]   m0 [NR];
    logic [31:0]   m1 [NR];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_slave_regfile #(.dw(32), .aw(32), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_o0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0),
        .busy_i(busy), .reg_q(regq0), .wr_stb_o(wstb0), .wr_idx_o(widx0)
    );

    wb_slave_regfile #(.dw(32), .aw(32), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut1 (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_o1), .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1),
        .busy_i(busy), .reg_q(regq1), .wr_stb_o(wstb1), .wr_idx_o(widx1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sample(input int inst, output logic [31:0] d, output logic [2:0] resp,
                          output logic ws, output logic [7:0] wi);
        if (inst == 1) begin
            d = dat_o1; resp = {ack1, err1, rty1}; ws = wstb1; wi = widx1;
        end else begin
            d = dat_o0; resp = {ack0, err0, rty0}; ws = wstb0; wi = widx0;
        end
    endtask

    task automatic check_regs(input int inst);
        for (int k = 0; k < NR; k++) begin
            if (inst == 1) check($sformatf("reg_q1[%0d]", k), regq1[k*32 +: 32], m1[k]);
            else           check($sformatf("reg_q0[%0d]", k), regq0[k*32 +: 32], m0[k]);
        end
    endtask

    task automatic set_idle();
        cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; busy = 1'b0; we = 1'b0;
    endtask

    // One complete transfer: drive request, walk cycle by cycle to the
    // expected response, check it, then check the bus returns quiet.
    task automatic xfer(input int inst, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w, input logic b, input logic late);
        logic [31:0] off, mask, exp_d, old, got_d;
        logic [2:0]  exp_resp, got_resp;
        logic        valid, got_ws;
        logic [7:0]  got_wi;
        int          idx, lat;
        off   = a - BASE;
        valid = (off % 4 == 0) && (off < NR * 4);
        idx   = valid ? int'(off / 4) : 0;
        old   = (inst == 1) ? m1[idx] : m0[idx];
        if (b)          begin exp_resp = 3'b001; lat = 0; end
        else if (!valid) begin exp_resp = 3'b010; lat = 0; end
        else            begin exp_resp = 3'b100; lat = (inst == 1) ? 3 : 0; end
        exp_d = (exp_resp == 3'b100 && !w) ? old : 32'h0;

        adr = a; dat_i = d; sel = s; we = w; busy = b; stb = 1'b1;
        if (inst == 1) cyc1 = 1'b1; else cyc0 = 1'b1;
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            if (late && k == 0) busy = 1'b1;
            sample(inst, got_d, got_resp, got_ws, got_wi);
            if (k < lat) check("no_resp_during_wait", {29'd0, got_resp}, 32'd0);
        end
        check("resp_kind", {29'd0, got_resp}, {29'd0, exp_resp});
        check("rd_data", got_d, exp_d);
        check("wr_stb", {31'd0, got_ws}, {31'd0, exp_resp == 3'b100 && w});
        if (exp_resp == 3'b100 && w) begin
            check("wr_idx", {24'd0, got_wi}, idx);
            mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            if (inst == 1) m1[idx] = (old & ~mask) | (d & mask);
            else           m0[idx] = (old & ~mask) | (d & mask);
        end
        check_regs(inst);
        set_idle();
        @(posedge clk); #1;
        sample(inst, got_d, got_resp, got_ws, got_wi);
        check("idle_after_resp", {29'd0, got_resp}, 32'd0);
        check("idle_data", got_d, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d, got_d;
        logic [2:0]  got_resp;
        logic        got_ws;
        logic [7:0]  got_wi;
        int          inst, r;

        for (int k = 0; k < NR; k++) begin m0[k] = 32'h0; m1[k] = 32'h0; end
        cti = 3'd0; bte = 2'd0; adr = '0; dat_i = '0; sel = '0;
        set_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_resp0", {29'd0, ack0, err0, rty0}, 32'd0);
        check("reset_data0", dat_o0, 32'd0);
        check("reset_wstb0", {31'd0, wstb0}, 32'd0);
        check("reset_resp1", {29'd0, ack1, err1, rty1}, 32'd0);
        check_regs(0);
        check_regs(1);
        @(posedge clk); #1;

        xfer(0, 32'h108, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0);
        check("reg2_direct", regq0[95:64], 32'hDEADBEEF);
        xfer(0, 32'h108, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        xfer(0, 32'h100, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0);
        xfer(0, 32'h100, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 1'b0);
        check("lane_merge", regq0[31:0], 32'h11BB33DD);
        xfer(0, 32'h100, 32'h55555555, 4'h0, 1'b1, 1'b0, 1'b0);
        xfer(0, 32'h140, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        xfer(0, 32'h102, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        xfer(0, 32'h0FC, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        xfer(0, 32'h10C, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 1'b0);
        xfer(1, 32'h104, 32'h0BADC0DE, 4'hF, 1'b1, 1'b0, 1'b1);
        xfer(1, 32'h104, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);

        // Request held through the response is taken again after one idle cycle.
        adr = 32'h108; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc0 = 1'b1;
        @(posedge clk); #1;
        check("b2b_first_ack", {31'd0, ack0}, 32'd1);
        check("b2b_first_data", dat_o0, m0[2]);
        @(posedge clk); #1;
        check("b2b_gap", {29'd0, ack0, err0, rty0}, 32'd0);
        @(posedge clk); #1;
        check("b2b_second_ack", {31'd0, ack0}, 32'd1);
        check("b2b_second_data", dat_o0, m0[2]);
        set_idle();
        @(posedge clk); #1;

        // Strobe dropped two cycles into a 3-wait-state write: no response, no write.
        adr = 32'h110; dat_i = 32'h12345678; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 stb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            sample(1, got_d, got_resp, got_ws, got_wi);
            check("abort_no_resp", {28'd0, got_ws, got_resp}, 32'd0);
        end
        set_idle();
        check_regs(1);

        for (int i = 0; i < 150; i++) begin
            inst = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r    = $urandom_range(0, 9);
            a    = BASE + 32'(4 * $urandom_range(0, NR - 1));
            if (r == 7)      a = BASE + 32'(NR * 4) + 32'(4 * $urandom_range(0, 15));
            else if (r == 8) a = a + 32'($urandom_range(1, 3));
            else if (r == 9) a = BASE - 32'(4 * $urandom_range(1, 4));
            d = $urandom;
            xfer(inst, a, d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, inst == 1 && $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a waited write clears everything.
        adr = 32'h11C; dat_i = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        for (int k = 0; k < NR; k++) begin m0[k] = 32'h0; m1[k] = 32'h0; end
        check("rst_mid_resp1", {28'd0, wstb1, ack1, err1, rty1}, 32'd0);
        check("rst_mid_data1", dat_o1, 32'd0);
        check("rst_mid_widx1", {24'd0, widx1}, 32'd0);
        check("rst_mid_widx0", {24'd0, widx0}, 32'd0);
        check_regs(0);
        check_regs(1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("rst_no_late_resp", {28'd0, wstb1, ack1, err1, rty1}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
